// File: rtl/dmem_pkg.sv
// Shared types and defaults for the data-memory responder: FSM state encoding,
// default geometry/latency and the address legality check.
package dmem_pkg;

  localparam int unsigned DEFAULT_DEPTH_WORDS = 256;
  localparam int unsigned DEFAULT_LATENCY     = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // An access is illegal when it is not word aligned or its word index
  // falls beyond the end of the array.
  function automatic logic addr_error(input logic [31:0] addr,
                                      input int unsigned depth);
    return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= 32'(depth));
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised data array: synchronous byte-enabled write, registered read.
// A read happens on an enabled cycle with no byte lanes written.
module dmem_array #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          en,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  // NOTE: the storage array is deliberately left without a reset so it maps
  // onto RAM macros; only control state elsewhere is reset.
  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 4; i++) begin
        if (we[i]) begin
          mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
      if (we == 4'b0000) begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the pipeline MEM stage: accepts one request,
// waits LATENCY cycles, then holds a response until the pipeline takes it.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
  parameter int unsigned LATENCY     = DEFAULT_LATENCY
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned CW = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
  localparam logic [CW-1:0] CNT_LOAD = (LATENCY > 1) ? CW'(LATENCY - 2) : '0;

  typedef struct packed {
    logic          write;
    logic          err;
    logic [AW-1:0] idx;
    logic [31:0]   wdata;
    logic [3:0]    be;
  } req_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  req_t          req_q, req_in, acc;
  logic          accept, access;
  logic          rsp_err_q, rsp_load_q;
  logic          arr_en;
  logic [3:0]    arr_we;
  logic [31:0]   arr_rdata;

  always_comb begin
    req_in.write = req_write;
    req_in.err   = addr_error(req_addr, DEPTH_WORDS);
    req_in.idx   = req_addr[AW+1:2];
    req_in.wdata = req_wdata;
    req_in.be    = req_be;
  end

  // Ready is held low while reset is asserted even though the state is IDLE.
  assign req_ready = reset & ((state_q == IDLE) | ((state_q == RESP) & rsp_ready));
  assign accept    = req_valid & req_ready;

  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    access  = 1'b0;
    acc     = req_q;
    case (state_q)
      IDLE: ;
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
          access  = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Accept never coincides with WAIT, so this cannot collide with the
    // countdown-expiry access above.
    if (accept) begin
      if (LATENCY == 1) begin
        state_d = RESP;
        access  = 1'b1;
        acc     = req_in;
      end else begin
        state_d = WAIT;
        cnt_d   = CNT_LOAD;
      end
    end
  end

  assign arr_en = access & ~acc.err;
  assign arr_we = (access & acc.write & ~acc.err) ? acc.be : 4'b0000;

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_array (
    .clk   (clk),
    .en    (arr_en),
    .we    (arr_we),
    .addr  (acc.idx),
    .wdata (acc.wdata),
    .rdata (arr_rdata)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      req_q      <= '0;
      rsp_err_q  <= 1'b0;
      rsp_load_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        req_q <= req_in;
      end
      if (access) begin
        rsp_err_q  <= acc.err;
        rsp_load_q <= ~acc.write & ~acc.err;
      end
    end
  end

  // Response flags only change on an access edge, so the response stays
  // stable for as long as RESP is held by backpressure.
  assign rsp_valid = (state_q == RESP);
  assign rsp_err   = rsp_valid & rsp_err_q;
  assign rsp_rdata = (rsp_valid & rsp_load_q) ? arr_rdata : 32'h0;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder at DEPTH_WORDS=256, LATENCY=2 with
// hand-computed expected values.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid, rsp_ready, rsp_err, busy;
  logic [31:0] rsp_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete transaction; rsp_ready is held low for `hold` cycles in RESP.
  task automatic do_req(input string tag, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be, input int hold,
                        input logic [31:0] exp_rdata, input logic exp_err);
    int n;
    int lat;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin
      step();
      n++;
    end
    if (!req_ready) check({tag, "_ready_timeout"}, 32'(req_ready), 32'd1);
    step();
    req_valid = 1'b0;
    check({tag, "_wait_ready"}, 32'(req_ready), 32'd0);
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      step();
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'd2);
    check({tag, "_rdata"}, rsp_rdata, exp_rdata);
    check({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
    for (int i = 0; i < hold; i++) begin
      step();
      check({tag, "_hold_valid"}, 32'(rsp_valid), 32'd1);
      check({tag, "_hold_rdata"}, rsp_rdata, exp_rdata);
      check({tag, "_hold_err"}, 32'(rsp_err), 32'(exp_err));
      check({tag, "_hold_ready"}, 32'(req_ready), 32'd0);
      check({tag, "_hold_busy"}, 32'(busy), 32'd1);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [31:0] b2b_addr [4];
    logic [31:0] b2b_exp  [4];
    int          acc_cyc  [4];
    int          cyc, k, r;
    logic        acc, got, idle_seen;

    reset     = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_be    = '0;
    rsp_ready = 1'b0;

    // Reset state
    repeat (3) step();
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_err",   32'(rsp_err),   32'd0);
    check("rst_rsp_rdata", rsp_rdata,      32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    #3 reset = 1'b1;
    step();
    check("rel_req_ready", 32'(req_ready), 32'd1);

    // Store then load
    do_req("st_10", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 32'h0, 1'b0);
    do_req("ld_10", 1'b0, 32'h10, 32'h0, 4'h0, 0, 32'hDEADBEEF, 1'b0);

    // Partial store: lanes 0 and 2 of 0x11223344 over 0xAABBCCDD
    do_req("st_14", 1'b1, 32'h14, 32'hAABBCCDD, 4'hF, 0, 32'h0, 1'b0);
    do_req("pst_14", 1'b1, 32'h14, 32'h11223344, 4'h5, 0, 32'h0, 1'b0);
    do_req("ld_14", 1'b0, 32'h14, 32'h0, 4'h0, 0, 32'hAA22CC44, 1'b0);

    // Backpressure for 3 cycles
    do_req("bp_ld_10", 1'b0, 32'h10, 32'h0, 4'h0, 3, 32'hDEADBEEF, 1'b0);

    // Error paths and boundaries
    do_req("st_0", 1'b1, 32'h0, 32'h0BADF00D, 4'hF, 0, 32'h0, 1'b0);
    do_req("ld_mis", 1'b0, 32'h6, 32'h0, 4'h0, 0, 32'h0, 1'b1);
    do_req("st_oor", 1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, 0, 32'h0, 1'b1);
    do_req("ld_0_after_oor", 1'b0, 32'h0, 32'h0, 4'h0, 0, 32'h0BADF00D, 1'b0);
    do_req("st_mis", 1'b1, 32'h12, 32'h0, 4'hF, 0, 32'h0, 1'b1);
    do_req("ld_10_after_mis", 1'b0, 32'h10, 32'h0, 4'h0, 0, 32'hDEADBEEF, 1'b0);
    do_req("st_be0", 1'b1, 32'h10, 32'h0, 4'h0, 0, 32'h0, 1'b0);
    do_req("ld_10_after_be0", 1'b0, 32'h10, 32'h0, 4'h0, 0, 32'hDEADBEEF, 1'b0);
    do_req("st_last", 1'b1, 32'h3FC, 32'hCAFE0001, 4'hF, 0, 32'h0, 1'b0);
    do_req("ld_last", 1'b0, 32'h3FC, 32'h0, 4'h0, 0, 32'hCAFE0001, 1'b0);
    do_req("ld_oor_first", 1'b0, 32'h400, 32'h0, 4'h0, 0, 32'h0, 1'b1);

    // Back-to-back loads with req_valid and rsp_ready held high
    b2b_addr = '{32'h10, 32'h14, 32'h0, 32'h3FC};
    b2b_exp  = '{32'hDEADBEEF, 32'hAA22CC44, 32'h0BADF00D, 32'hCAFE0001};
    acc_cyc  = '{0, 0, 0, 0};
    rsp_ready = 1'b1;
    req_write = 1'b0;
    req_addr  = b2b_addr[0];
    req_valid = 1'b1;
    cyc = 0;
    k = 0;
    r = 0;
    idle_seen = 1'b0;
    while (r < 4 && cyc < 60) begin
      acc = req_valid && req_ready;
      got = rsp_valid && rsp_ready;
      if (got) begin
        check("b2b_rdata", rsp_rdata, b2b_exp[r]);
        r++;
      end
      if (k > 0 && k < 4 && !busy) idle_seen = 1'b1;
      if (acc) begin
        acc_cyc[k] = cyc;
        k++;
      end
      step();
      cyc++;
      if (acc) begin
        if (k < 4) req_addr = b2b_addr[k];
        else req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    check("b2b_responses", 32'(r), 32'd4);
    check("b2b_accepts", 32'(k), 32'd4);
    for (int i = 1; i < 4; i++) begin
      check("b2b_interval", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd2);
    end
    check("b2b_no_idle", 32'(idle_seen), 32'd0);
    step();

    // Reset during WAIT discards the pending store
    do_req("st_20", 1'b1, 32'h20, 32'h12345678, 4'hF, 0, 32'h0, 1'b0);
    req_write = 1'b1;
    req_addr  = 32'h20;
    req_wdata = 32'h55;
    req_be    = 4'hF;
    req_valid = 1'b1;
    check("mw_pre_ready", 32'(req_ready), 32'd1);
    step();
    req_valid = 1'b0;
    check("mw_in_wait_busy", 32'(busy), 32'd1);
    #1 reset = 1'b0;
    #1;
    check("mw_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("mw_rst_rsp_err",   32'(rsp_err),   32'd0);
    check("mw_rst_rsp_rdata", rsp_rdata,      32'd0);
    check("mw_rst_busy",      32'(busy),      32'd0);
    check("mw_rst_req_ready", 32'(req_ready), 32'd0);
    step();
    check("mw_rst_hold_valid", 32'(rsp_valid), 32'd0);
    #2 reset = 1'b1;
    step();
    check("mw_rel_req_ready", 32'(req_ready), 32'd1);
    do_req("ld_20_after_rst", 1'b0, 32'h20, 32'h0, 4'h0, 0, 32'h12345678, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends on its own.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256: number of 32-bit words; a power of two, at least 4.
REQ-002 SHALL have parameter LATENCY, default 2: cycles from request accept to first rsp_valid; at least 1.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port req_valid, input, 1 bit: the pipeline MEM stage presents a request.
REQ-006 SHALL have port req_ready, output, 1 bit: the responder accepts a request this cycle.
REQ-007 SHALL have port req_write, input, 1 bit: 1 is a store, 0 is a load.
REQ-008 SHALL have port req_addr, input, 32 bits: byte address.
REQ-009 SHALL have port req_wdata, input, 32 bits: store data.
REQ-010 SHALL have port req_be, input, 4 bits: byte enables for stores; bit i selects bits [8i+7:8i].
REQ-011 SHALL have port rsp_valid, output, 1 bit: a response is present.
REQ-012 SHALL have port rsp_ready, input, 1 bit: the pipeline consumes the response.
REQ-013 SHALL have port rsp_rdata, output, 32 bits: load data; 0 for stores and errors.
REQ-014 SHALL have port rsp_err, output, 1 bit: the access was misaligned or out of range.
REQ-015 SHALL have port busy, output, 1 bit: high when the FSM is not in IDLE; used as the pipeline stall source.

Function
REQ-016 SHALL have FSM states IDLE, WAIT and RESP.
REQ-017 SHALL define a request as accepted on a rising edge where req_valid and req_ready are both high.
REQ-018 SHALL drive req_ready = (state==IDLE) | (state==RESP & rsp_ready).
REQ-019 SHALL, on accept, capture write, address, wdata and be into request registers.
REQ-020 SHALL, on accept, go to RESP if LATENCY==1, else go to WAIT with the countdown loaded to LATENCY-2.
REQ-021 SHALL, in WAIT, decrement the countdown each cycle and go to RESP when it reaches 0, so rsp_valid first rises LATENCY cycles after the accept edge.
REQ-022 SHALL perform the array access on the WAIT/IDLE->RESP transition edge: a store commits to the array and rsp_rdata is registered.
REQ-023 SHALL, in RESP, hold rsp_valid, rsp_rdata and rsp_err stable until rsp_ready is high.
REQ-024 SHALL, when rsp_ready and req_valid are both high in RESP, accept the new request in the same edge (back-to-back); otherwise RESP with rsp_ready goes to IDLE.
REQ-025 SHALL treat req_addr[1:0]!=0 as misaligned.
REQ-026 SHALL treat a word index req_addr[31:2] >= DEPTH_WORDS as out of range.
REQ-027 SHALL, for a misaligned or out-of-range request, set rsp_err=1 and rsp_rdata=0, and leave the array unmodified; timing is the same as a normal request.
REQ-028 SHALL, for a store with req_be=0, modify nothing and return rsp_err=0.
REQ-029 SHALL return the updated word on a load that follows a store to the same address, with no hazard window.
REQ-030 SHALL ignore the req_* inputs while in WAIT.

Reset
REQ-031 SHALL, while reset is low, force state=IDLE, countdown=0, rsp_valid=0, rsp_rdata=0, rsp_err=0 and busy=0; req_ready SHALL be 0 during reset and 1 on the first cycle after release.
REQ-032 SHALL, if reset asserts during WAIT, discard the pending store without committing it.
REQ-033 SHALL NOT reset array contents.

Structure
REQ-034 SHALL place in shared package dmem_pkg: the state enum type (IDLE, WAIT, RESP) and the DEPTH_WORDS and LATENCY default constants.
REQ-035 SHALL instantiate one sub-module, dmem_array: synchronous byte-enabled write and registered read, with no reset.
REQ-036 SHALL keep the FSM, countdown, error check and request registers in dmem_responder.

Verification
REQ-037 SHALL cover a store then load at LATENCY=2: store addr 0x10, data 0xDEADBEEF, be 0xF accepted at cycle 0 -> rsp_valid at cycle 2, rsp_err=0; load 0x10 -> rsp_rdata=0xDEADBEEF.
REQ-038 SHALL cover a partial store: store 0x11223344 with be 0x5 to a word holding 0xAABBCCDD -> a subsequent load returns 0xAA22CC44.
REQ-039 SHALL cover response backpressure: rsp_ready held low 3 cycles in RESP -> rsp_valid and rsp_rdata stable, req_ready=0 and busy=1 throughout.
REQ-040 SHALL cover error paths: load at addr 0x6 -> rsp_err=1 and rdata=0; store at addr 0x400 with DEPTH_WORDS=256 -> rsp_err=1 and array unchanged.
REQ-041 SHALL cover back-to-back requests: req_valid and rsp_ready held high continuously -> one accept every LATENCY+0 cycles after the first, with no IDLE gap.
REQ-042 SHALL cover reset mid-WAIT: store 0x55 to addr 0x20 with reset pulsed low in WAIT -> all outputs 0 immediately; a load of 0x20 after release returns the prior contents.
